// File: rtl/esfa_vector_fetch_if.sv
// ROM read port and decoded-vector output stream of the vector fetcher.
// The master side is the fetcher; the slave side is the ROM and consumer.
interface esfa_vector_fetch_if;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic [63:0] rom_data;

    logic        out_valid;
    logic        out_ready;
    logic        out_is_mutating;
    logic        out_expected_bool;
    logic        out_is_metadata;
    logic [7:0]  out_new_index;
    logic [7:0]  out_new_value;
    logic [7:0]  out_metadata;
    logic [7:0]  out_selector;
    logic [7:0]  out_expected_value;
    logic [31:0] out_addr;

    modport master (
        output rom_en, rom_addr,
        input  rom_data,
        output out_valid,
        input  out_ready,
        output out_is_mutating, out_expected_bool, out_is_metadata, out_new_index,
               out_new_value, out_metadata, out_selector, out_expected_value, out_addr
    );

    modport slave (
        input  rom_en, rom_addr,
        output rom_data,
        input  out_valid,
        output out_ready,
        input  out_is_mutating, out_expected_bool, out_is_metadata, out_new_index,
               out_new_value, out_metadata, out_selector, out_expected_value, out_addr
    );
endinterface

// File: rtl/esfa_vector_fetch.sv
// Streams test vectors out of a block ROM until an end marker (bit 2) or an
// overrun limit, buffering decoded vectors in a small FIFO with credit-based issue.
module esfa_vector_fetch #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MAX_VECTORS = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    esfa_vector_fetch_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [31:0]          vector_count
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [31:0] MaxV = 32'(MAX_VECTORS);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic              rom_en_q, rom_en_d;
    logic [31:0]       rom_addr_q, rom_addr_d;
    logic [31:0]       next_addr_q, next_addr_d;
    logic              pend_q, pend_d;
    logic [31:0]       pend_addr_q, pend_addr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       vcount_q, vcount_d;

    // Entry layout: {source address, raw word bits 47:0}.
    logic [79:0]       mem_q [FIFO_DEPTH];

    logic              push, pop, issue, end_seen;
    logic [31:0]       occ;
    logic [79:0]       head;
    logic              head_valid;

    assign head_valid = (count_q != '0);
    assign pop        = head_valid && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        rom_en_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        next_addr_d = next_addr_q;
        pend_d      = rom_en_q;
        pend_addr_d = rom_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        vcount_d    = vcount_q;
        push        = 1'b0;
        issue       = 1'b0;
        end_seen    = 1'b0;
        // Words already issued still occupy a slot; a same-cycle pop earns no credit.
        occ         = 32'(count_q) + 32'(rom_en_q) + 32'(pend_q);

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StFetch;
                    next_addr_d = '0;
                    vcount_d    = '0;
                    overrun_d   = 1'b0;
                end
            end
            StFetch: begin
                if (pend_q) begin
                    if (bus.rom_data[2]) end_seen = 1'b1;
                    else                 push     = 1'b1;
                end
                if (!end_seen && (next_addr_q < MaxV) && (occ < FIFO_DEPTH)) begin
                    issue = 1'b1;
                end
                if (end_seen) begin
                    state_d = StDrain;
                end else if ((next_addr_q == MaxV) && !rom_en_q && !pend_q) begin
                    overrun_d = 1'b1;
                    state_d   = StDrain;
                end
            end
            StDrain: ;
            default: state_d = StIdle;
        endcase

        if (issue) begin
            rom_en_d    = 1'b1;
            rom_addr_d  = next_addr_q;
            next_addr_d = next_addr_q + 32'd1;
        end

        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            vcount_d = vcount_q + 32'd1;
        end
        if (push && !pop)      count_d = count_q + CntW'(1);
        else if (!push && pop) count_d = count_q - CntW'(1);

        if ((state_q == StDrain) && (count_d == '0)) state_d = StDone;

        busy_d = (state_d == StFetch) || (state_d == StDrain);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rom_en_q    <= 1'b0;
            rom_addr_q  <= '0;
            next_addr_q <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            vcount_q    <= '0;
        end else begin
            state_q     <= state_d;
            rom_en_q    <= rom_en_d;
            rom_addr_q  <= rom_addr_d;
            next_addr_q <= next_addr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            vcount_q    <= vcount_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {pend_addr_q, bus.rom_data[47:0]};
    end

    assign head = head_valid ? mem_q[rd_ptr_q] : '0;

    assign bus.rom_en             = rom_en_q;
    assign bus.rom_addr           = rom_addr_q;
    assign bus.out_valid          = head_valid;
    assign bus.out_is_mutating    = head[0];
    assign bus.out_expected_bool  = head[1];
    assign bus.out_is_metadata    = head[3];
    assign bus.out_new_index      = head[15:8];
    assign bus.out_new_value      = head[23:16];
    assign bus.out_metadata       = head[31:24];
    assign bus.out_selector       = head[39:32];
    assign bus.out_expected_value = head[47:40];
    assign bus.out_addr           = head[79:48];

    assign busy         = busy_q;
    assign done         = done_q;
    assign overrun      = overrun_q;
    assign vector_count = vcount_q;

endmodule

// File: tb/tb_esfa_vector_fetch.sv
// Directed bench for esfa_vector_fetch: end-marker runs, stalls, overrun,
// async reset mid-transfer and restart from DONE.
module tb_esfa_vector_fetch;

    localparam int unsigned Depth = 4;
    localparam int unsigned MaxV  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, overrun;
    logic [31:0] vector_count;

    esfa_vector_fetch_if bus ();

    esfa_vector_fetch #(
        .FIFO_DEPTH  (Depth),
        .MAX_VECTORS (MaxV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .vector_count (vector_count)
    );

    always #5 clk = ~clk;

    logic [63:0] rom [16];

    // Synchronous ROM: address captured at the edge, data visible after it.
    initial bus.rom_data = '0;
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr[3:0]];
    end

    int total = 0;
    int bad   = 0;

    function automatic logic [47:0] obs_word();
        return {bus.out_expected_value, bus.out_selector, bus.out_metadata,
                bus.out_new_value, bus.out_new_index, 4'b0000, bus.out_is_metadata,
                1'b0, bus.out_expected_bool, bus.out_is_mutating};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Passive monitor: transfers, issued addresses, valid cycles, stall stability.
    logic [31:0] xa [$];
    logic [47:0] xd [$];
    logic [31:0] ia [$];
    int          valid_n  = 0;
    int          stab_err = 0;
    logic        stall_q  = 1'b0;
    logic [47:0] prev_w   = '0;
    logic [31:0] prev_a   = '0;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            xa.push_back(bus.out_addr);
            xd.push_back(obs_word());
        end
        if (bus.rom_en) ia.push_back(bus.rom_addr);
        if (bus.out_valid) valid_n <= valid_n + 1;
        if (stall_q && (!bus.out_valid || obs_word() != prev_w || bus.out_addr != prev_a))
            stab_err <= stab_err + 1;
        stall_q <= bus.out_valid && !bus.out_ready;
        prev_w  <= obs_word();
        prev_a  <= bus.out_addr;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0] = 64'hDEAD_A1B2_C3D4_E509;
        rom[1] = 64'h0000_1122_3344_5502;
        rom[2] = 64'h1234_FFEE_DDCC_BBF1;
        rom[3] = 64'h0000_0000_0000_0004;
    endtask

    task automatic check_basic(input string tag, input int base);
        logic [47:0] exp_w [3];
        exp_w[0] = 48'hA1B2_C3D4_E509;
        exp_w[1] = 48'h1122_3344_5502;
        exp_w[2] = 48'hFFEE_DDCC_BB01;
        check({tag, "_xfers"}, 64'(xa.size() - base), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < xa.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 64'(xa[base+i]), 64'(i));
                check($sformatf("%s_data%0d", tag, i), 64'(xd[base+i]), 64'(exp_w[i]));
            end
        end
        check({tag, "_count"}, 64'(vector_count), 64'd3);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_rom_en"}, 64'(bus.rom_en), 64'd0);
        check({tag, "_rom_addr"}, 64'(bus.rom_addr), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_overrun"}, 64'(overrun), 64'd0);
        check({tag, "_vcount"}, 64'(vector_count), 64'd0);
        check({tag, "_fields"}, 64'(obs_word()), 64'd0);
        check({tag, "_out_addr"}, 64'(bus.out_addr), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int xb, ib, vb, hit;
        logic [31:0] amax;

        bus.out_ready = 1'b1;
        load_basic();
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_rom_en", 64'(bus.rom_en), 64'd0);

        // Three vectors then end marker, consumer always ready.
        xb = xa.size();
        pulse_start();
        check("run_busy", 64'(busy), 64'd1);
        wait_done("run_done");
        repeat (2) @(negedge clk);
        check_basic("run", xb);

        // Restart from DONE reruns from address 0.
        xb = xa.size();
        ib = ia.size();
        pulse_start();
        check("rerun_vcount_clr", 64'(vector_count), 64'd0);
        check("rerun_done_clr", 64'(done), 64'd0);
        wait_done("rerun_done");
        repeat (2) @(negedge clk);
        check_basic("rerun", xb);
        check("rerun_first_issue", (ia.size() > ib) ? 64'(ia[ib]) : 64'hFFFF, 64'd0);

        // Consumer stalls six cycles after the first valid.
        bus.out_ready = 1'b0;
        xb = xa.size();
        ib = ia.size();
        pulse_start();
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        check("stall_valid_seen", 64'(hit), 64'd1);
        repeat (6) @(negedge clk);
        check("stall_no_xfer", 64'(xa.size() - xb), 64'd0);
        check("stall_issued", 64'(ia.size() - ib), 64'(Depth));
        check("stall_head_addr", 64'(bus.out_addr), 64'd0);
        bus.out_ready = 1'b1;
        wait_done("stall_done");
        repeat (2) @(negedge clk);
        check("stall_stable", 64'(stab_err), 64'd0);
        check_basic("stall", xb);

        // End marker at address 0: nothing delivered.
        for (int i = 0; i < 16; i++) rom[i] = '0;
        rom[0] = 64'h4;
        xb = xa.size();
        vb = valid_n;
        pulse_start();
        wait_done("empty_done");
        repeat (2) @(negedge clk);
        check("empty_xfers", 64'(xa.size() - xb), 64'd0);
        check("empty_valid", 64'(valid_n - vb), 64'd0);
        check("empty_vcount", 64'(vector_count), 64'd0);
        check("empty_overrun", 64'(overrun), 64'd0);

        // No end marker: limit of 8 words, overrun flagged.
        for (int i = 0; i < 16; i++)
            rom[i] = {16'h0, 8'(8'hA0 + i), 8'(i), 8'(2 * i), 8'(i + 3), 8'(8'h10 + i), 8'h09};
        xb = xa.size();
        ib = ia.size();
        pulse_start();
        wait_done("ovr_done");
        repeat (2) @(negedge clk);
        check("ovr_xfers", 64'(xa.size() - xb), 64'd8);
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_vcount", 64'(vector_count), 64'd8);
        check("ovr_issued", 64'(ia.size() - ib), 64'd8);
        amax = '0;
        for (int i = ib; i < ia.size(); i++) if (ia[i] > amax) amax = ia[i];
        check("ovr_addr_max", 64'(amax), 64'd7);
        if (xa.size() - xb == 8) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("ovr_addr%0d", i), 64'(xa[xb+i]), 64'(i));
            check("ovr_data5", 64'(xd[xb+5]), 64'h00A5_050A_0815_09);
        end

        // Async reset while the second vector is on the bus.
        load_basic();
        pulse_start();
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_addr == 32'd1) begin
                hit = 1;
                break;
            end
        end
        check("rst_mid_reached", 64'(hit), 64'd1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("rst_mid");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        xb = xa.size();
        ib = ia.size();
        repeat (10) @(negedge clk);
        check("rst_idle_xfers", 64'(xa.size() - xb), 64'd0);
        check("rst_idle_issue", 64'(ia.size() - ib), 64'd0);
        check("rst_idle_busy", 64'(busy), 64'd0);
        check("rst_idle_done", 64'(done), 64'd0);

        xb = xa.size();
        pulse_start();
        wait_done("post_rst_done");
        repeat (2) @(negedge clk);
        check_basic("post_rst", xb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
